// File: rtl/bias_accum_sat_if.sv
// Bias/partial-sum sink bus: beat stream in, packed per-lane results out.
// master drives beats and bias; slave (bias_accum_sat) returns results and status.
interface bias_accum_sat_if #(
  parameter int N_adder_tree = 16
);
  logic [N_adder_tree*18-1:0] bias;
  logic [7:0]                 num_pass;
  logic                       in_valid;
  logic                       in_ready;
  logic [N_adder_tree*18-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [N_adder_tree*18-1:0] out_data;
  logic                       busy;

  modport master (
    output bias, num_pass, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  bias, num_pass, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/bias_accum_sat.sv
// Per-lane accumulate of num_pass beats + bias, 18-bit saturate (ReLU under BIAS_ACCUM_RELU_EN).
// Latency: out_valid one cycle after the last beat edge; period npass+2 with out_ready high.
// Backpressure: in_ready low in BIAS/HOLD; HOLD keeps out_data stable until out_ready.
module bias_accum_sat #(
  parameter int N_adder_tree = 16,
  parameter int ACC_W        = 26
) (
  input  logic         clk,
  input  logic         rst,
  bias_accum_sat_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_BIAS  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(131071);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-131072);

  logic [1:0]                 state;
  logic [7:0]                 cnt;
  logic [7:0]                 npass;
  logic                       out_valid_q;
  logic [N_adder_tree*18-1:0] out_data_q;
  logic [N_adder_tree*18-1:0] lane_res;
  logic                       in_ready_c;
  logic                       accept;
  logic                       first;

  // in_ready depends on state alone so upstream never sees a combinational loop
  assign in_ready_c = (state == S_IDLE) || (state == S_ACCUM);
  assign accept     = bus.in_valid && in_ready_c;
  assign first      = (state == S_IDLE);

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state != S_IDLE);

  for (genvar g = 0; g < N_adder_tree; g++) begin : g_lane
    logic signed [17:0]      in_l;
    logic signed [17:0]      bias_l;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [17:0]      sat;

    assign in_l   = bus.in_data[18*g +: 18];
    assign bias_l = bus.bias[18*g +: 18];
    assign sum    = acc + ACC_W'(bias_l);

    always_comb begin
      if (sum > SAT_MAX)
        sat = 18'sh1FFFF;
      else if (sum < SAT_MIN)
        sat = 18'sh20000;
      else
        sat = sum[17:0];
`ifdef BIAS_ACCUM_RELU_EN
      if (sat < 0)
        sat = '0;
`endif
    end

    assign lane_res[18*g +: 18] = sat;

    // first beat overwrites, so no residue survives between results
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        acc <= '0;
      else if (accept)
        acc <= first ? ACC_W'(in_l) : acc + ACC_W'(in_l);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      npass       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt   <= 8'd1;
            npass <= (bus.num_pass == 8'd0) ? 8'd1 : bus.num_pass;
            state <= (bus.num_pass <= 8'd1) ? S_BIAS : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            cnt <= cnt + 8'd1;
            if (cnt + 8'd1 == npass)
              state <= S_BIAS;
          end
        end
        S_BIAS: begin
          out_data_q  <= lane_res;
          out_valid_q <= 1'b1;
          state       <= S_HOLD;
        end
        default: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bias_accum_sat.sv
// Randomized bench for bias_accum_sat against a plain-arithmetic per-lane model.
module tb_bias_accum_sat;
  localparam int N = 16;
  localparam int W = N * 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bias_accum_sat_if #(.N_adder_tree(N)) bus ();

  bias_accum_sat #(.N_adder_tree(N), .ACC_W(26)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int             n_cmp = 0;
  int             n_err = 0;
  logic [W-1:0]   beats[$];
  logic [W-1:0]   last_out;
  longint         t_rise;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint lane_of(input logic [W-1:0] v, input int i);
    logic signed [17:0] t;
    t = v[18*i +: 18];
    return longint'(t);
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 5))
        0:       v[18*i +: 18] = 18'h1FFFF;
        1:       v[18*i +: 18] = 18'h20000;
        default: v[18*i +: 18] = 18'($urandom);
      endcase
    end
    return v;
  endfunction

  function automatic longint expect_lane(input longint s);
    longint r;
    r = s;
    if (r > 131071)  r = 131071;
    if (r < -131072) r = -131072;
`ifdef BIAS_ACCUM_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  task automatic send_beat(input logic [W-1:0] d);
    int waited;
    waited = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) check("rdy_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Runs one full result from the beats queue; np is the raw num_pass value.
  task automatic do_result(input int np, input int gap, input bit hold, input string tag);
    int     npe;
    longint s;
    logic [W-1:0] held;
    npe = (np == 0) ? 1 : np;
    bus.out_ready = !hold;
    bus.num_pass  = 8'(np);
    for (int k = 0; k < npe; k++) begin
      send_beat(beats[k]);
      if (k == 0) bus.num_pass = 8'($urandom);
      if (gap > 0 && k < npe - 1) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    check({tag, "_bias_ov"}, bus.out_valid, 0);
    check({tag, "_bias_rdy"}, bus.in_ready, 0);
    @(negedge clk);
    t_rise = longint'($time);
    check({tag, "_ov"}, bus.out_valid, 1);
    check({tag, "_busy"}, bus.busy, 1);
    for (int i = 0; i < N; i++) begin
      s = lane_of(bus.bias, i);
      for (int k = 0; k < npe; k++) s += lane_of(beats[k], i);
      check($sformatf("%s_lane%0d", tag, i), lane_of(bus.out_data, i), expect_lane(s));
    end
    last_out = bus.out_data;
    if (hold) begin
      held = bus.out_data;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'($urandom);
        bus.in_data  = rnd_word();
        @(negedge clk);
        check({tag, "_hold_stable"}, bus.out_data == held, 1);
        check({tag, "_hold_rdy"}, bus.in_ready, 0);
        check({tag, "_hold_ov"}, bus.out_valid, 1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "_done_ov"}, bus.out_valid, 0);
    check({tag, "_done_busy"}, bus.busy, 0);
    check({tag, "_done_rdy"}, bus.in_ready, 1);
  endtask

  task automatic fill(input int n);
    beats.delete();
    for (int k = 0; k < n; k++) beats.push_back(rnd_word());
  endtask

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] b;
    logic [W-1:0] save;
    longint       prev;
    int           np;

    rst           = 1'b1;
    bus.bias      = '0;
    bus.num_pass  = 8'd1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ov", bus.out_valid, 0);
    check("rst_rdy", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_data_zero", |bus.out_data, 0);

    // num_pass=1: lane0 100 + (-30)
    b = rnd_word();
    b[17:0] = 18'h3FFE2;
    bus.bias = b;
    w = rnd_word();
    w[17:0] = 18'd100;
    beats.delete();
    beats.push_back(w);
    do_result(1, 0, 0, "np1");
    check("np1_lane0_70", lane_of(last_out, 0), 70);

    // saturation at both rails
    b = rnd_word();
    b[18*5 +: 18] = '0;
    b[18*6 +: 18] = '0;
    bus.bias = b;
    fill(3);
    beats[0][18*5 +: 18] = 18'h1FFFF;
    beats[1][18*5 +: 18] = 18'h1FFFF;
    beats[2][18*5 +: 18] = 18'd5;
    for (int k = 0; k < 3; k++) beats[k][18*6 +: 18] = 18'h20000;
    do_result(3, 0, 0, "sat");
    check("sat_hi_lane5", lane_of(last_out, 5), 131071);
`ifdef BIAS_ACCUM_RELU_EN
    check("sat_lo_lane6", lane_of(last_out, 6), 0);
`else
    check("sat_lo_lane6", lane_of(last_out, 6), -131072);
`endif

    // num_pass=0 behaves as 1
    bus.bias = rnd_word();
    fill(1);
    do_result(0, 0, 0, "np0");

    // gaps inside ACCUM give the same result as gap-free
    bus.bias = rnd_word();
    fill(3);
    do_result(3, 3, 0, "gap");
    save = last_out;
    do_result(3, 0, 0, "nogap");
    check("gap_equal", last_out == save, 1);

    // backpressure in HOLD with ignored in_valid pulses
    bus.bias = rnd_word();
    fill(2);
    do_result(2, 0, 1, "hold");

    // reset after 2 of 4 beats
    bus.bias = rnd_word();
    fill(4);
    bus.num_pass = 8'd4;
    send_beat(beats[0]);
    send_beat(beats[1]);
    #2;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ov", bus.out_valid, 0);
    check("mid_rst_rdy", bus.in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", bus.in_ready, 1);
    check("post_rst_busy", bus.busy, 0);
    fill(4);
    do_result(4, 0, 0, "fresh");

    // back-to-back num_pass=2 -> one result every 4 cycles
    bus.bias = rnd_word();
    prev = 0;
    for (int r = 0; r < 5; r++) begin
      fill(2);
      do_result(2, 0, 0, "b2b");
      if (r > 0) check("b2b_period", t_rise - prev, 40);
      prev = t_rise;
    end

    // random mix
    for (int r = 0; r < 15; r++) begin
      bus.bias = rnd_word();
      np = $urandom_range(0, 6);
      fill((np == 0) ? 1 : np);
      do_result(np, $urandom_range(0, 2), ($urandom_range(0, 4) == 0), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
